// File: rtl/layer_compositor.sv
// layer_compositor: priority/colour-key layer mux with global fade, fixed-latency pixel pipeline
// and frame-synchronous double-buffered configuration.
module layer_compositor #(
  parameter int          N_LAYERS    = 6,
  parameter int          COLOR_W     = 8,
  parameter int          PIPE_STAGES = 2,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           de_in,
  input  logic                           frame_start,
  input  logic [N_LAYERS-1:0]            layer_en,
  input  logic [N_LAYERS*3*COLOR_W-1:0]  layer_rgb,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [N_LAYERS-1:0]            cfg_mask,
  input  logic [N_LAYERS-1:0]            cfg_key_en,
  input  logic [3*COLOR_W-1:0]           cfg_key_color,
  input  logic [3:0]                     cfg_fade,
  output logic [COLOR_W-1:0]             r,
  output logic [COLOR_W-1:0]             g,
  output logic [COLOR_W-1:0]             b,
  output logic                           de_out
);
  localparam int PW = 3*COLOR_W;

  function automatic logic [COLOR_W-1:0] rs(input logic [7:0] v);
    logic [COLOR_W-1:0] o;
    o = '0;
    for (int i = 0; i < COLOR_W && i < 8; i++) o[i] = v[i];
    return o;
  endfunction

  function automatic logic [COLOR_W-1:0] fd(input logic [COLOR_W-1:0] c, input logic [3:0] f);
    logic [4:0] m;
    m = 5'd16 - {1'b0, f};
    return COLOR_W'(({5'b0, c} * {{COLOR_W{1'b0}}, m}) >> 4);
  endfunction

  localparam logic [PW-1:0] BG = {rs(BG_COLOR[23:16]), rs(BG_COLOR[15:8]), rs(BG_COLOR[7:0])};

  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_nx;
  logic accept, apply;
  logic [N_LAYERS-1:0] sh_mask, sh_key_en, act_mask, act_key_en;
  logic [PW-1:0] sh_key, act_key;
  logic [3:0] sh_fade, act_fade;

  always_comb begin
    cfg_ready = state == IDLE;
    accept    = cfg_valid && state == IDLE;
    apply     = frame_start && state == PENDING;
    state_nx  = accept ? PENDING : apply ? IDLE : state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_mask <= '1;
      sh_key_en <= '0;
      sh_key <= '0;
      sh_fade <= '0;
      act_mask <= '1;
      act_key_en <= '0;
      act_key <= '0;
      act_fade <= '0;
    end else begin
      if (accept) begin
        sh_mask <= cfg_mask;
        sh_key_en <= cfg_key_en;
        sh_key <= cfg_key_color;
        sh_fade <= cfg_fade;
      end
      if (apply) begin
        act_mask <= sh_mask;
        act_key_en <= sh_key_en;
        act_key <= sh_key;
        act_fade <= sh_fade;
      end
    end

  // Ascending scan so the highest visible index overwrites lower ones.
  logic [PW-1:0] sel, px;
  always_comb begin
    sel = BG;
    px = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      px = layer_rgb[i*PW +: PW];
      if (layer_en[i] && act_mask[i] && !(act_key_en[i] && px == act_key)) sel = px;
    end
  end

  logic [PW-1:0] s1_rgb, faded;
  logic s1_de;
  logic [3:0] s1_fade;
  logic [PW-1:0] p_rgb [2:PIPE_STAGES];
  logic p_de [2:PIPE_STAGES];

  assign faded = {fd(s1_rgb[PW-1 -: COLOR_W], s1_fade), fd(s1_rgb[2*COLOR_W-1 -: COLOR_W], s1_fade),
                  fd(s1_rgb[COLOR_W-1:0], s1_fade)};

  // Blank pixels are zeroed on entry; fading zero keeps them zero downstream.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_rgb <= '0;
      s1_de <= 1'b0;
      s1_fade <= '0;
      for (int i = 2; i <= PIPE_STAGES; i++) begin
        p_rgb[i] <= '0;
        p_de[i] <= 1'b0;
      end
    end else begin
      s1_rgb <= de_in ? sel : '0;
      s1_de <= de_in;
      s1_fade <= act_fade;
      p_rgb[2] <= faded;
      p_de[2] <= s1_de;
      for (int i = 3; i <= PIPE_STAGES; i++) begin
        p_rgb[i] <= p_rgb[i-1];
        p_de[i] <= p_de[i-1];
      end
    end

  assign {r, g, b} = p_rgb[PIPE_STAGES];
  assign de_out = p_de[PIPE_STAGES];
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed scoreboard bench; stimulus pushes expected pixels, a monitor checks them.
module tb_layer_compositor;
  localparam int N = 6;
  localparam int C = 8;
  localparam int P = 2;

  logic clk = 0, rst_n = 0, de_in = 0, frame_start = 0, cfg_valid = 0;
  logic cfg_ready, de_out;
  logic [N-1:0] layer_en = '0, cfg_mask = '1, cfg_key_en = '0;
  logic [N*3*C-1:0] layer_rgb = '0;
  logic [3*C-1:0] cfg_key_color = '0;
  logic [3:0] cfg_fade = '0;
  logic [C-1:0] r, g, b;

  layer_compositor #(.N_LAYERS(N), .COLOR_W(C), .PIPE_STAGES(P), .BG_COLOR(24'h000000)) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .frame_start(frame_start), .layer_en(layer_en),
    .layer_rgb(layer_rgb), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mask(cfg_mask),
    .cfg_key_en(cfg_key_en), .cfg_key_color(cfg_key_color), .cfg_fade(cfg_fade),
    .r(r), .g(g), .b(b), .de_out(de_out));

  always #5 clk = ~clk;

  typedef struct {logic [23:0] rgb; int due;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  bit mon_en = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && mon_en) begin
      if (de_out) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pixel: got %h at cycle %0d, none expected", {r, g, b}, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({r, g, b} !== e.rgb || cyc != e.due) begin
            fails++;
            $display("FAIL pixel: got %h at cycle %0d, expected %h at cycle %0d", {r, g, b}, cyc, e.rgb, e.due);
          end
        end
      end else begin
        check("blank_rgb", {8'h0, r, g, b}, 32'h0);
        if (q.size() != 0 && q[0].due <= cyc) begin
          tests++;
          fails++;
          $display("FAIL missing_pixel: got none at cycle %0d, expected %h", cyc, q[0].rgb);
          void'(q.pop_front());
        end
      end
    end

  task automatic set_layer(input int i, input logic [23:0] c);
    layer_rgb[i*24 +: 24] = c;
  endtask

  task automatic px(input logic [N-1:0] en, input logic [23:0] exp, input bit push = 1);
    de_in = 1;
    layer_en = en;
    if (push) q.push_back('{exp, cyc + P});
    @(posedge clk); #1;
    de_in = 0;
    layer_en = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame();
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
  endtask

  task automatic send_cfg(input logic [N-1:0] m, input logic [N-1:0] k, input logic [23:0] kc,
                          input logic [3:0] f);
    cfg_mask = m; cfg_key_en = k; cfg_key_color = kc; cfg_fade = f;
    cfg_valid = 1;
    @(posedge clk); #1;
    cfg_valid = 0;
    check("cfg_accept_ready_low", {31'h0, cfg_ready}, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", {8'h0, r, g, b}, 32'h0);
    check("reset_de_out", {31'h0, de_out}, 32'h0);
    check("reset_cfg_ready", {31'h0, cfg_ready}, 32'h1);
    rst_n = 1;
    idle(2);
    set_layer(0, 24'h0A0B0C); set_layer(1, 24'h111111); set_layer(2, 24'h123456);
    set_layer(3, 24'h333333); set_layer(4, 24'h444444); set_layer(5, 24'hABCDEF);
    px(6'b100101, 24'hABCDEF);
    px(6'b000101, 24'h123456);
    px(6'b000001, 24'h0A0B0C);
    px(6'b000000, 24'h000000);
    idle(3);
    send_cfg(6'h3F, 6'b100000, 24'hFF00FF, 4'd0);
    idle(1);
    check("pending_ready_low", {31'h0, cfg_ready}, 32'h0);
    frame();
    check("apply_ready_high", {31'h0, cfg_ready}, 32'h1);
    set_layer(5, 24'hFF00FF);
    px(6'b100100, 24'h123456);
    set_layer(5, 24'hFF00FE);
    px(6'b100100, 24'hFF00FE);
    idle(2);
    cfg_mask = 6'h3F; cfg_key_en = '0; cfg_key_color = '0; cfg_fade = 4'd8;
    cfg_valid = 1;
    @(posedge clk); #1;
    check("hs_accept_ready_low", {31'h0, cfg_ready}, 32'h0);
    cfg_fade = 4'd15;
    repeat (3) begin
      @(posedge clk); #1;
      check("hs_hold_ready_low", {31'h0, cfg_ready}, 32'h0);
    end
    cfg_valid = 0;
    frame();
    check("hs_reassert", {31'h0, cfg_ready}, 32'h1);
    set_layer(0, 24'hFF8010);
    px(6'b000001, 24'h7F4008);
    send_cfg(6'h3F, 6'h00, 24'h0, 4'd15);
    frame();
    px(6'b000001, 24'h0F0801);
    send_cfg(6'h3F, 6'h00, 24'h0, 4'd0);
    frame();
    px(6'b000001, 24'hFF8010);
    px(6'b000000, 24'h000000);
    set_layer(5, 24'hABCDEF);
    send_cfg(6'h1F, 6'h00, 24'h0, 4'd0);
    px(6'b100001, 24'hABCDEF);
    frame();
    px(6'b100001, 24'hFF8010);
    cfg_mask = 6'h3F; cfg_valid = 1; frame_start = 1;
    @(posedge clk); #1;
    cfg_valid = 0; frame_start = 0;
    check("coinc_accept_ready_low", {31'h0, cfg_ready}, 32'h0);
    px(6'b100001, 24'hFF8010);
    frame();
    px(6'b100001, 24'hABCDEF);
    frame();
    px(6'b100001, 24'hABCDEF);
    idle(4);
    mon_en = 0;
    send_cfg(6'h00, 6'h00, 24'h0, 4'd8);
    px(6'b100001, 24'h0, 0);
    px(6'b100001, 24'h0, 0);
    de_in = 1; layer_en = 6'b100001;
    rst_n = 0;
    #1;
    check("rst_rgb", {8'h0, r, g, b}, 32'h0);
    check("rst_de_out", {31'h0, de_out}, 32'h0);
    check("rst_cfg_ready", {31'h0, cfg_ready}, 32'h1);
    de_in = 0; layer_en = '0;
    @(posedge clk); #1;
    rst_n = 1;
    mon_en = 1;
    px(6'b100001, 24'hABCDEF);
    px(6'b000001, 24'hFF8010);
    frame();
    px(6'b100001, 24'hABCDEF);
    idle(P + 3);
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    check("queue_drained", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
